// File: rtl/seg_pkg.sv
// Shared seven-segment display definitions: digit codes, bus geometry and
// the formatter state encoding. Optional macro: LEADING_ZERO_BLANK_EN.
package seg_pkg;

  localparam logic [3:0] CODE_C     = 4'd10;
  localparam logic [3:0] CODE_DASH  = 4'd11;
  localparam logic [3:0] CODE_D     = 4'd12;
  localparam logic [3:0] CODE_L     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_DISPLAY = 9999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } fmt_state_t;

  // Replace zero digits above the most significant nonzero digit; digit0 always shown.
  function automatic logic [BCD_W-1:0] blank_leading_zeros(
    input logic [BCD_W-1:0] digits,
    input logic [DIGIT_W-1:0] blank
  );
    logic [BCD_W-1:0] r;
    r = digits;
    if (digits[15:12] == 4'd0) begin
      r[15:12] = blank;
      if (digits[11:8] == 4'd0) begin
        r[11:8] = blank;
        if (digits[7:4] == 4'd0) begin
          r[7:4] = blank;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_nib,
  output logic [DIGIT_W-1:0] o_nib_c
);

  always_comb begin
    o_nib_c = i_nib;
    if (i_nib >= DIGIT_W'(5)) begin
      o_nib_c = DIGIT_W'(i_nib + DIGIT_W'(3));
    end
  end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-BCD converter feeding the 4-digit display bus, with
// overflow dashes and optional leading-zero blanking (LEADING_ZERO_BLANK_EN).
module bcd_display_formatter
  import seg_pkg::*;
#(
  parameter int unsigned     IN_W       = 14,
  parameter logic [3:0]      BLANK_CODE = CODE_BLANK,
  parameter logic [3:0]      OVF_CODE   = CODE_DASH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   value,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  nums,
  output logic              ovf
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  fmt_state_t       r_state;
  logic [IN_W-1:0]  r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pending;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_nums;
  logic             r_ovf;

  logic [BCD_W-1:0] w_bcd_adj;
  logic [BCD_W-1:0] w_fmt;
  logic             w_value_ovf;

  assign busy = r_busy;
  assign done = r_done;
  assign nums = r_nums;
  assign ovf  = r_ovf;

  assign w_value_ovf = (32'(value) > 32'(MAX_DISPLAY));

  // Per-decade +3 correction applied before every shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib   (r_bcd[g*DIGIT_W +: DIGIT_W]),
      .o_nib_c (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Display formatting of the finished accumulator.
  always_comb begin
    w_fmt = r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
    w_fmt = blank_leading_zeros(r_bcd, BLANK_CODE);
`else
    w_fmt = r_bcd;
`endif
    if (r_ovf_pending) begin
      w_fmt = {NUM_DIGITS{OVF_CODE}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bin         <= '0;
      r_bcd         <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_nums        <= {NUM_DIGITS{BLANK_CODE}};
      r_ovf         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin         <= value;
            r_bcd         <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= w_value_ovf;
            r_busy        <= 1'b1;
            r_state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Thousands-nibble carry-out is dropped; only reachable on overflow.
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[IN_W-1]};
          r_bin <= r_bin << 1;
          if (r_cnt == CNT_W'(IN_W - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_FORMAT;
          end else begin
            r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
          end
        end
        ST_FORMAT: begin
          r_nums  <= w_fmt;
          r_ovf   <= r_ovf_pending;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
